// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
//   state_e    : sequencer FSM states
//   idx_w()    : bits needed to index 0..n-1 (minimum 1)
//   stage_w()  : width of the domain index / stage_o
//   hold_cnt_w(): width of the per-domain hold counter
//   wait_cnt_w(): width of the ready-timeout counter
package rst_seq_pkg;

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_HOLD  = 3'd1,
        S_WAIT  = 3'd2,
        S_RUN   = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int stage_w(input int n_domains);
        return idx_w(n_domains);
    endfunction

    function automatic int hold_cnt_w(input int hold_cycles);
        return idx_w(hold_cycles);
    endfunction

    function automatic int wait_cnt_w(input int timeout_cycles);
        return idx_w(timeout_cycles);
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Reset synchroniser: asserts asynchronously with arst_n, deasserts
// SYNC_STAGES clock edges after arst_n is released.
// Ports:
//   clk          : clock
//   arst_n       : asynchronous active-low reset
//   sync_rst_n_o : synchronised active-low reset
module rst_seq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    output logic sync_rst_n_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // A constant 1 is shifted in; the chain only clears on arst_n.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_rst_n_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Board-level reset sequencer. Synchronises arst_n, then releases the
// downstream reset domains one by one (index 0 first), each after a hold
// period and only once the previous domain reports ready.
// Optional feature macro: RST_SEQ_TIMEOUT_EN (ready timeout + S_FAULT).
// Ports:
//   clk         : clock
//   arst_n      : asynchronous active-low reset
//   sw_rst_i    : software reset request (level), restarts the sequence
//   dom_ready_i : per-domain ready, bit k only sampled while waiting on k
//   rst_n_o     : registered active-low per-domain resets
//   seq_done_o  : all domains released and ready
//   stage_o     : index of the domain currently being sequenced
//   fault_o     : sticky ready-timeout flag (0 without the macro)
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_DOMAINS      = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          sw_rst_i,
    input  logic [N_DOMAINS-1:0]          dom_ready_i,
    output logic [N_DOMAINS-1:0]          rst_n_o,
    output logic                          seq_done_o,
    output logic [stage_w(N_DOMAINS)-1:0] stage_o,
    output logic                          fault_o
);

    localparam int STAGE_W = stage_w(N_DOMAINS);
    localparam int HOLD_W  = hold_cnt_w(HOLD_CYCLES);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_DOMAINS - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

    if (N_DOMAINS < 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_params
        $error("reset_sequencer: illegal parameter value");
    end

    logic sync_rst_n;

    rst_seq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk          (clk),
        .arst_n       (arst_n),
        .sync_rst_n_o (sync_rst_n)
    );

    state_e               state_q, state_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [N_DOMAINS-1:0] rst_n_q, rst_n_d;
    logic                 seq_done_q, seq_done_d;

`ifdef RST_SEQ_TIMEOUT_EN
    localparam int WAIT_W = wait_cnt_w(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              fault_q, fault_d;
`endif

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        hold_cnt_d = hold_cnt_q;
        rst_n_d    = rst_n_q;
`ifdef RST_SEQ_TIMEOUT_EN
        wait_cnt_d = '0;  // only survives while staying in S_WAIT
`endif
        // Nothing moves until the synchronised reset has been released.
        if (sync_rst_n) begin
            if (sw_rst_i) begin
                // Held in S_HOLD with a cleared counter while the request
                // is high; counting restarts once it drops.
                state_d    = S_HOLD;
                stage_d    = '0;
                hold_cnt_d = '0;
                rst_n_d    = '0;
            end else begin
                unique case (state_q)
                    S_SYNC: state_d = S_HOLD;
                    S_HOLD: begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            rst_n_d[stage_q] = 1'b1;
                            hold_cnt_d       = '0;
                            state_d          = S_WAIT;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                    S_WAIT: begin
                        if (dom_ready_i[stage_q]) begin
                            if (stage_q == LAST_STAGE) begin
                                state_d = S_RUN;
                            end else begin
                                stage_d = stage_q + STAGE_W'(1);
                                state_d = S_HOLD;
                            end
                        end
`ifdef RST_SEQ_TIMEOUT_EN
                        else if (wait_cnt_q == WAIT_LAST) begin
                            // stage_q is left untouched to report the culprit.
                            rst_n_d = '0;
                            state_d = S_FAULT;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        end
`endif
                    end
                    S_RUN, S_FAULT: ;  // only sw_rst_i or arst_n leave these
                    default: state_d = S_SYNC;
                endcase
            end
        end
    end

    // Registered flags follow the state being entered.
    assign seq_done_d = (state_d == S_RUN);
`ifdef RST_SEQ_TIMEOUT_EN
    assign fault_d = (state_d == S_FAULT);
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_SYNC;
            stage_q    <= '0;
            hold_cnt_q <= '0;
            rst_n_q    <= '0;
            seq_done_q <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            hold_cnt_q <= hold_cnt_d;
            rst_n_q    <= rst_n_d;
            seq_done_q <= seq_done_d;
`ifdef RST_SEQ_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
`endif
        end
    end

    assign rst_n_o    = rst_n_q;
    assign seq_done_o = seq_done_q;
    assign stage_o    = stage_q;
`ifdef RST_SEQ_TIMEOUT_EN
    assign fault_o = fault_q;
`else
    assign fault_o = 1'b0;
`endif

endmodule
